// File: rtl/di_stall_target.sv
// rtl/di_stall_target.sv - DI-bus stall test target with programmable wait/burst counter channels (optional STAT counter: DI_STALL_TARGET_ERRCNT_EN)
module di_stall_target #(
   parameter int          DATA_WIDTH = 16,
   parameter int          NUM_CH     = 4,
   parameter logic [15:0] EP_ADDR    = 16'h0010,
   parameter logic [15:0] REG_BASE   = 16'h0000,
   parameter int          WAIT_BITS  = 5,
   parameter int          INIT_WAIT  = 5,
   parameter int          BURST_LEN  = 8
) (
   input  logic                  if_clock,
   input  logic                  resetb,
   input  logic [15:0]           diEpAddr,
   input  logic [15:0]           diRegAddr,
   input  logic [DATA_WIDTH-1:0] diRegDataIn,
   input  logic                  diWrite,
   input  logic                  diRead,
   output logic [DATA_WIDTH-1:0] diRegDataOut,
   output logic                  rd_ready,
   output logic                  wr_ready
);

   localparam int BW = $clog2(BURST_LEN + 1);

   typedef enum logic {ST_WAIT = 1'b0, ST_READY = 1'b1} ch_state_t;

   ch_state_t             state      [NUM_CH];
   ch_state_t             state_nxt  [NUM_CH];
   logic [WAIT_BITS-1:0]  wait_cnt   [NUM_CH];
   logic [WAIT_BITS-1:0]  wait_nxt   [NUM_CH];
   logic [BW-1:0]         burst_cnt  [NUM_CH];
   logic [BW-1:0]         burst_nxt  [NUM_CH];
   logic [DATA_WIDTH-1:0] cnt        [NUM_CH];
   logic [DATA_WIDTH-1:0] cnt_nxt    [NUM_CH];

   logic [WAIT_BITS-1:0]  cfg_w;
   logic                  cfg_burst;
   logic [BW-1:0]         burst_limit;
   logic [DATA_WIDTH-1:0] cfg_rd;
   logic [DATA_WIDTH-1:0] stat_rd;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  ready_nxt;

   logic                  ep_hit;
   logic [15:0]           offset;
   logic [NUM_CH-1:0]     ch_hit;
   logic                  cfg_hit;
   logic                  stat_hit;
   logic                  strobe;

   assign ep_hit      = (diEpAddr == EP_ADDR);
   assign offset      = diRegAddr - REG_BASE;
   assign cfg_hit     = ep_hit && (offset == 16'(NUM_CH));
   assign stat_hit    = ep_hit && (offset == 16'(NUM_CH + 1));
   assign strobe      = diRead | diWrite;
   assign burst_limit = cfg_burst ? BW'(BURST_LEN) : BW'(1);

   // Channel select: one-hot hit for the channel register being addressed
   always_comb begin
      ch_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_hit[i] = ep_hit && (offset == 16'(i));
      end
   end

   // Per-channel next state: wait countdown, burst accounting and counter update
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_nxt[i] = state[i];
         wait_nxt[i]  = wait_cnt[i];
         burst_nxt[i] = burst_cnt[i];
         cnt_nxt[i]   = cnt[i];
         if (state[i] == ST_WAIT) begin
            // Accesses here are dropped; only the countdown advances
            if (wait_cnt[i] >= cfg_w) begin
               state_nxt[i] = ST_READY;
               wait_nxt[i]  = '0;
               burst_nxt[i] = '0;
            end else begin
               wait_nxt[i] = wait_cnt[i] + WAIT_BITS'(1);
            end
         end else if (ch_hit[i] && strobe) begin
            // Write wins over a simultaneous read; both together use one slot
            if (diWrite) begin
               cnt_nxt[i] = diRegDataIn;
            end else begin
               cnt_nxt[i] = cnt[i] + DATA_WIDTH'(1);
            end
            // >= so a shrunken limit after a CFG write still closes the window
            if ((burst_cnt[i] + BW'(1)) >= burst_limit) begin
               state_nxt[i] = ST_WAIT;
               wait_nxt[i]  = '0;
               burst_nxt[i] = '0;
            end else begin
               burst_nxt[i] = burst_cnt[i] + BW'(1);
            end
         end
      end
   end

   // CFG readback image
   always_comb begin
      cfg_rd                = '0;
      cfg_rd[WAIT_BITS-1:0] = cfg_w;
      cfg_rd[WAIT_BITS]     = cfg_burst;
   end

   // Ready and read-data source for the addressed register; unmapped space is always ready
   always_comb begin
      ready_nxt = 1'b1;
      data_nxt  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_hit[i]) begin
            ready_nxt = (state_nxt[i] == ST_READY);
            data_nxt  = cnt[i];
         end
      end
      if (cfg_hit) begin
         data_nxt = cfg_rd;
      end
      if (stat_hit) begin
         data_nxt = stat_rd;
      end
   end

   // Channel FSMs, counters and configuration register
   always_ff @(posedge if_clock) begin
      if (!resetb) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i]     <= ST_WAIT;
            wait_cnt[i]  <= '0;
            burst_cnt[i] <= '0;
            cnt[i]       <= DATA_WIDTH'(i);
         end
         cfg_w     <= WAIT_BITS'(INIT_WAIT);
         cfg_burst <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i]     <= state_nxt[i];
            wait_cnt[i]  <= wait_nxt[i];
            burst_cnt[i] <= burst_nxt[i];
            cnt[i]       <= cnt_nxt[i];
         end
         if (cfg_hit && diWrite) begin
            cfg_w     <= diRegDataIn[WAIT_BITS-1:0];
            cfg_burst <= diRegDataIn[WAIT_BITS];
         end
      end
   end

   // Registered ready flags and read data for the selected register
   always_ff @(posedge if_clock) begin
      if (!resetb) begin
         rd_ready     <= 1'b0;
         wr_ready     <= 1'b0;
         diRegDataOut <= '0;
      end else begin
         rd_ready     <= ready_nxt;
         wr_ready     <= ready_nxt;
         diRegDataOut <= data_nxt;
      end
   end

`ifdef DI_STALL_TARGET_ERRCNT_EN
   logic [15:0] err_cnt;
   logic        violation;

   // Flag any strobe aimed at a channel that is still counting down
   always_comb begin
      violation = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_hit[i] && strobe && (state[i] != ST_READY)) begin
            violation = 1'b1;
         end
      end
   end

   // Saturating violation counter, cleared by any STAT write
   always_ff @(posedge if_clock) begin
      if (!resetb) begin
         err_cnt <= '0;
      end else if (stat_hit && diWrite) begin
         err_cnt <= '0;
      end else if (violation && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end

   assign stat_rd = DATA_WIDTH'(err_cnt);
`else
   assign stat_rd = '0;
`endif

endmodule
